// File: rtl/hc595_frame_capture.sv
// Receive side of a 74HC595 seven-segment link: oversamples ds/shcp/stcp/oe, rebuilds each
// 14-bit latched word {seg, sel}, decodes digit codes and reports complete 6-digit frames.
module hc595_frame_capture #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        ds,
  input  logic        shcp,
  input  logic        stcp,
  input  logic        oe,
  output logic        word_valid,
  output logic [13:0] word,
  output logic        frame_valid,
  output logic [23:0] digits,
  output logic [5:0]  dp,
  output logic        disp_off,
  output logic        bit_err,
  output logic        sel_err,
  output logic        link_alive
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] ds_sync, shcp_sync, stcp_sync, oe_sync;
  logic                   shcp_prev, stcp_prev;
  logic                   shcp_rise, stcp_rise, ds_bit;
  logic [13:0]            shift_reg, shift_next;
  logic [3:0]             bit_cnt, cnt_next;
  logic [5:0]             seen, seen_next;
  logic [TW-1:0]          to_cnt;
  logic                   timed_out;
  logic [7:0]             seg;
  logic [5:0]             sel;
  logic [2:0]             pos;
  logic [3:0]             code;
  logic                   sel_ok;

  // Identical chains keep ds aligned with shcp through the synchroniser.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ds_sync   <= '0;
      shcp_sync <= '0;
      stcp_sync <= '0;
      oe_sync   <= '0;
      shcp_prev <= 1'b0;
      stcp_prev <= 1'b0;
      shcp_rise <= 1'b0;
      stcp_rise <= 1'b0;
      ds_bit    <= 1'b0;
    end else begin
      ds_sync   <= {ds_sync[SYNC_STAGES-2:0], ds};
      shcp_sync <= {shcp_sync[SYNC_STAGES-2:0], shcp};
      stcp_sync <= {stcp_sync[SYNC_STAGES-2:0], stcp};
      oe_sync   <= {oe_sync[SYNC_STAGES-2:0], oe};
      shcp_prev <= shcp_sync[SYNC_STAGES-1];
      stcp_prev <= stcp_sync[SYNC_STAGES-1];
      shcp_rise <= shcp_sync[SYNC_STAGES-1] & ~shcp_prev;
      stcp_rise <= stcp_sync[SYNC_STAGES-1] & ~stcp_prev;
      ds_bit    <= ds_sync[SYNC_STAGES-1];
    end
  end

  assign disp_off = oe_sync[SYNC_STAGES-1];

  // A shift in the same sample as the latch is applied before the count check.
  always_comb begin
    shift_next = shift_reg;
    cnt_next   = bit_cnt;
    if (shcp_rise) begin
      if (bit_cnt < 4'd14) shift_next[bit_cnt] = ds_bit;
      if (bit_cnt != 4'd15) cnt_next = bit_cnt + 4'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      bit_err    <= 1'b0;
    end else begin
      shift_reg  <= shift_next;
      word_valid <= 1'b0;
      bit_err    <= 1'b0;
      if (stcp_rise) begin
        bit_cnt <= '0;
        if (cnt_next == 4'd14) begin
          word       <= shift_next;
          word_valid <= 1'b1;
        end else begin
          bit_err <= 1'b1;
        end
      end else begin
        bit_cnt <= cnt_next;
      end
    end
  end

  function automatic logic [3:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40:   seg_decode = 4'h0;
      7'h79:   seg_decode = 4'h1;
      7'h24:   seg_decode = 4'h2;
      7'h30:   seg_decode = 4'h3;
      7'h19:   seg_decode = 4'h4;
      7'h12:   seg_decode = 4'h5;
      7'h02:   seg_decode = 4'h6;
      7'h78:   seg_decode = 4'h7;
      7'h00:   seg_decode = 4'h8;
      7'h10:   seg_decode = 4'h9;
      7'h7F:   seg_decode = 4'hA;
      7'h3F:   seg_decode = 4'hB;
      default: seg_decode = 4'hF;
    endcase
  endfunction

  assign seg    = word[13:6];
  assign sel    = word[5:0];
  assign sel_ok = $onehot(sel);
  assign code   = seg_decode(seg[6:0]);

  always_comb begin
    pos = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (sel[i]) pos = 3'(i);
    end
  end

  assign timed_out = (to_cnt == TW'(TIMEOUT_CYC));

  always_comb begin
    seen_next = frame_valid ? 6'h00 : seen;
    if (word_valid && sel_ok) seen_next = seen_next | sel;
    if (timed_out) seen_next = 6'h00;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      digits      <= '0;
      dp          <= '0;
      seen        <= '0;
      frame_valid <= 1'b0;
      sel_err     <= 1'b0;
      to_cnt      <= '0;
      link_alive  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sel_err     <= 1'b0;
      seen        <= seen_next;
      if (word_valid) begin
        if (sel_ok) begin
          digits[{pos, 2'b00} +: 4] <= code;
          dp[pos]                   <= ~seg[7];
          if (seen_next == 6'h3F) frame_valid <= 1'b1;
        end else begin
          sel_err <= 1'b1;
        end
      end
      if (stcp_rise) to_cnt <= '0;
      else if (!timed_out) to_cnt <= to_cnt + 1'b1;
      if (timed_out) link_alive <= 1'b0;
      else if (word_valid) link_alive <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hc595_frame_capture.sv
// Self-checking bench for hc595_frame_capture: drives 595-style serial words and compares
// against a word/frame-level reference model.
module tb_hc595_frame_capture;

  localparam int unsigned TO = 400;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        ds = 1'b0, shcp = 1'b0, stcp = 1'b0, oe = 1'b0;
  logic        word_valid, frame_valid, disp_off, bit_err, sel_err, link_alive;
  logic [13:0] word;
  logic [23:0] digits;
  logic [5:0]  dp;

  hc595_frame_capture #(.SYNC_STAGES(2), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe),
    .word_valid(word_valid), .word(word), .frame_valid(frame_valid), .digits(digits),
    .dp(dp), .disp_off(disp_off), .bit_err(bit_err), .sel_err(sel_err),
    .link_alive(link_alive)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0, n_fail = 0;
  int mon_wv = 0, mon_fv = 0, mon_be = 0, mon_se = 0;
  int exp_wv = 0, exp_fv = 0, exp_be = 0, exp_se = 0;

  always @(negedge sys_clk) begin
    if (word_valid)  mon_wv++;
    if (frame_valid) mon_fv++;
    if (bit_err)     mon_be++;
    if (sel_err)     mon_se++;
  end

  // Reference model state: last good word, digit codes, dp lamps, captured positions.
  logic [13:0] m_word = '0;
  logic [23:0] m_digits = '0;
  logic [5:0]  m_dp = '0, m_seen = '0;
  logic        m_alive = 1'b0;
  logic [7:0]  pat [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80,
                            8'h90};

  function automatic logic [3:0] ref_code(input logic [7:0] s);
    for (int i = 0; i < 10; i++) if ((s | 8'h80) == pat[i]) return 4'(i);
    if (s[6:0] == 7'h7F) return 4'hA;
    if (s[6:0] == 7'h3F) return 4'hB;
    return 4'hF;
  endfunction

  task automatic model_latch(input logic [7:0] s, input logic [5:0] sl, input int n);
    if (n != 14) begin
      exp_be++;
    end else begin
      exp_wv++;
      m_word  = {s, sl};
      m_alive = 1'b1;
      if ($countones(sl) == 1) begin
        for (int p = 0; p < 6; p++) begin
          if (sl[p]) begin
            m_digits[4*p +: 4] = ref_code(s);
            m_dp[p]            = ~s[7];
          end
        end
        m_seen = m_seen | sl;
        if (m_seen == 6'h3F) begin
          exp_fv++;
          m_seen = '0;
        end
      end else begin
        exp_se++;
      end
    end
  endtask

  task automatic model_reset();
    m_word = '0; m_digits = '0; m_dp = '0; m_seen = '0; m_alive = 1'b0;
  endtask

  task automatic shift_bits(input logic [13:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      ds   = (k < 14) ? w[k] : 1'($urandom);
      shcp = 1'b0;
      repeat ($urandom_range(3, 2)) @(posedge sys_clk);
      shcp = 1'b1;
      repeat ($urandom_range(3, 2)) @(posedge sys_clk);
    end
    shcp = 1'b0;
    repeat (2) @(posedge sys_clk);
  endtask

  task automatic pulse_stcp();
    stcp = 1'b1;
    repeat (2) @(posedge sys_clk);
    stcp = 1'b0;
    repeat (8) @(posedge sys_clk);
  endtask

  task automatic send(input logic [7:0] s, input logic [5:0] sl, input int n);
    shift_bits({s, sl}, n);
    pulse_stcp();
    model_latch(s, sl, n);
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    n_checks++; if (word !== 14'h0) begin n_fail++; $display("FAIL reset_word got %h want 0", word); end
    n_checks++; if (digits !== 24'h0) begin n_fail++; $display("FAIL reset_digits got %h want 0", digits); end
    n_checks++; if (dp !== 6'h0) begin n_fail++; $display("FAIL reset_dp got %b want 0", dp); end
    n_checks++; if (link_alive !== 1'b0) begin n_fail++; $display("FAIL reset_alive got %b want 0", link_alive); end
    n_checks++;
    if ({word_valid, frame_valid, bit_err, sel_err, disp_off} !== 5'b0) begin
      n_fail++; $display("FAIL reset_pulses got %b want 00000",
                         {word_valid, frame_valid, bit_err, sel_err, disp_off});
    end
    sys_rst = 1'b0;
    repeat (2) @(posedge sys_clk);
  endtask

  task automatic test_frame();
    logic [7:0] segs [6] = '{8'h92, 8'h99, 8'hB0, 8'h24, 8'hF9, 8'hC0};
    for (int p = 5; p >= 0; p--) send(segs[p], 6'(1 << p), 14);
    n_checks++; if (mon_fv !== 1) begin n_fail++; $display("FAIL frame_count got %0d want 1", mon_fv); end
    n_checks++; if (digits !== 24'h012345) begin n_fail++; $display("FAIL frame_digits got %h want 012345", digits); end
    n_checks++; if (dp !== 6'b001000) begin n_fail++; $display("FAIL frame_dp got %b want 001000", dp); end
    n_checks++; if (word !== {8'h92, 6'b000001}) begin n_fail++; $display("FAIL frame_word got %h want %h", word, {8'h92, 6'b000001}); end
    n_checks++; if (link_alive !== 1'b1) begin n_fail++; $display("FAIL frame_alive got %b want 1", link_alive); end
    n_checks++; if (mon_wv !== exp_wv) begin n_fail++; $display("FAIL frame_wv_count got %0d want %0d", mon_wv, exp_wv); end
  endtask

  task automatic test_bit_err();
    logic [13:0] held;
    held = m_word;
    send(8'h82, 6'b000100, 13);
    n_checks++; if (mon_be !== exp_be) begin n_fail++; $display("FAIL short_bit_err got %0d want %0d", mon_be, exp_be); end
    n_checks++; if (word !== held) begin n_fail++; $display("FAIL short_word_held got %h want %h", word, held); end
    send(8'h82, 6'b000100, 15);
    n_checks++; if (mon_be !== exp_be) begin n_fail++; $display("FAIL long_bit_err got %0d want %0d", mon_be, exp_be); end
    send(8'hF8, 6'b010000, 14);
    n_checks++; if (word !== m_word) begin n_fail++; $display("FAIL after_err_word got %h want %h", word, m_word); end
    n_checks++; if (mon_wv !== exp_wv) begin n_fail++; $display("FAIL after_err_wv got %0d want %0d", mon_wv, exp_wv); end
  endtask

  task automatic test_sel_err();
    send(8'hC0, 6'b000011, 14);
    send(8'hC0, 6'b000000, 14);
    n_checks++; if (mon_se !== exp_se) begin n_fail++; $display("FAIL sel_err_count got %0d want %0d", mon_se, exp_se); end
    n_checks++; if (digits !== m_digits) begin n_fail++; $display("FAIL sel_err_digits got %h want %h", digits, m_digits); end
    n_checks++; if (mon_fv !== exp_fv) begin n_fail++; $display("FAIL sel_err_frames got %0d want %0d", mon_fv, exp_fv); end
  endtask

  task automatic test_codes();
    send(8'hFF, 6'b000001, 14);
    send(8'hBF, 6'b000010, 14);
    send(8'h55, 6'b000100, 14);
    n_checks++; if (digits[11:0] !== 12'hFBA) begin n_fail++; $display("FAIL special_codes got %h want FBA", digits[11:0]); end
    n_checks++; if (dp[2:0] !== 3'b100) begin n_fail++; $display("FAIL special_dp got %b want 100", dp[2:0]); end
  endtask

  task automatic test_random();
    logic [7:0] s;
    logic [5:0] sl;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(9, 0) != 0) sl = 6'(1 << $urandom_range(5, 0));
      else sl = 6'($urandom);
      if ($urandom_range(3, 0) != 0) s = pat[$urandom_range(9, 0)] & ($urandom_range(1, 0) ? 8'hFF : 8'h7F);
      else s = 8'($urandom);
      send(s, sl, 14);
      n_checks++; if (word !== m_word) begin n_fail++; $display("FAIL rand_word it=%0d got %h want %h", it, word, m_word); end
      n_checks++; if (digits !== m_digits) begin n_fail++; $display("FAIL rand_digits it=%0d got %h want %h", it, digits, m_digits); end
      n_checks++; if (dp !== m_dp) begin n_fail++; $display("FAIL rand_dp it=%0d got %b want %b", it, dp, m_dp); end
      n_checks++;
      if (mon_fv !== exp_fv || mon_se !== exp_se) begin
        n_fail++; $display("FAIL rand_pulses it=%0d got fv=%0d se=%0d want fv=%0d se=%0d",
                           it, mon_fv, mon_se, exp_fv, exp_se);
      end
    end
  endtask

  task automatic test_timeout();
    for (int p = 0; p < 3; p++) send(pat[p], 6'(1 << p), 14);
    oe = 1'b1;
    repeat (TO + 50) @(posedge sys_clk);
    m_seen = '0; m_alive = 1'b0;
    @(negedge sys_clk);
    n_checks++; if (link_alive !== 1'b0) begin n_fail++; $display("FAIL timeout_alive got %b want 0", link_alive); end
    n_checks++; if (disp_off !== 1'b1) begin n_fail++; $display("FAIL disp_off got %b want 1", disp_off); end
    send(pat[3], 6'b001000, 14);
    n_checks++; if (link_alive !== m_alive) begin n_fail++; $display("FAIL relink_alive got %b want %b", link_alive, m_alive); end
    oe = 1'b0;
    for (int p = 4; p < 6; p++) send(pat[p], 6'(1 << p), 14);
    n_checks++; if (mon_fv !== exp_fv) begin n_fail++; $display("FAIL timeout_no_frame got %0d want %0d", mon_fv, exp_fv); end
    for (int p = 0; p < 3; p++) send(pat[p + 6], 6'(1 << p), 14);
    n_checks++; if (mon_fv !== exp_fv) begin n_fail++; $display("FAIL timeout_frame got %0d want %0d", mon_fv, exp_fv); end
    n_checks++; if (digits !== m_digits) begin n_fail++; $display("FAIL timeout_digits got %h want %h", digits, m_digits); end
  endtask

  task automatic test_reset_mid();
    shift_bits(14'h2AAA, 7);
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    model_reset();
    n_checks++;
    if ({word, digits, dp, link_alive} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs got %h/%h/%b/%b want 0", word, digits, dp, link_alive);
    end
    sys_rst = 1'b0;
    repeat (2) @(posedge sys_clk);
    send(8'h99, 6'b100000, 14);
    n_checks++; if (mon_be !== exp_be) begin n_fail++; $display("FAIL midreset_no_err got %0d want %0d", mon_be, exp_be); end
    n_checks++; if (word !== m_word) begin n_fail++; $display("FAIL midreset_word got %h want %h", word, m_word); end
    shift_bits(14'h1555, 7);
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    sys_rst = 1'b0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    send(8'h99, 6'b100000, 5);
    n_checks++; if (mon_be !== exp_be) begin n_fail++; $display("FAIL midreset_err got %0d want %0d", mon_be, exp_be); end
    n_checks++; if (word !== m_word) begin n_fail++; $display("FAIL midreset_word_held got %h want %h", word, m_word); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_bit_err();
    test_sel_err();
    test_codes();
    test_random();
    test_timeout();
    test_reset_mid();
    n_checks++; if (mon_wv !== exp_wv) begin n_fail++; $display("FAIL total_words got %0d want %0d", mon_wv, exp_wv); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
